// File: rtl/vga_frame_scheduler.sv
// VGA frame timing generator with a frame-boundary-synchronised pattern-mode register.
// Optional auto mode stepping is built when VGA_SCHED_AUTOCYCLE_EN is defined.
module vga_frame_scheduler #(
   parameter int   H_ACTIVE    = 640,
   parameter int   H_FP        = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BP        = 48,
   parameter int   V_ACTIVE    = 480,
   parameter int   V_FP        = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_BP        = 33,
   parameter logic SYNC_POL    = 1'b0,
   parameter int   AUTO_FRAMES = 60
) (
   input  logic       i_CLK,
   input  logic       i_RST,
   input  logic       i_CFG_VALID,
   input  logic [7:0] i_CFG_DATA,
   output logic       o_CFG_READY,
   output logic       o_HSYNC,
   output logic       o_VSYNC,
   output logic       o_ACTIVE,
   output logic [9:0] o_X,
   output logic [9:0] o_Y,
   output logic       o_FRAME_START,
   output logic [7:0] o_MODE
);

   localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic {IDLE, PENDING} state_t;

   logic [9:0] h, v, h_nxt, v_nxt;
   logic       h_wrap, fb;
   state_t     state, state_nxt;
   logic [7:0] shadow;

   always_comb begin
      h_wrap = (h == H_LAST);
      fb     = h_wrap && (v == V_LAST);
      h_nxt  = h_wrap ? 10'd0 : h + 10'd1;
      v_nxt  = v;
      if (h_wrap) v_nxt = (v == V_LAST) ? 10'd0 : v + 10'd1;
   end

   // Decode from next-state counters so registered flags line up with o_X/o_Y.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         h             <= '0;
         v             <= '0;
         o_ACTIVE      <= 1'b1;
         o_FRAME_START <= 1'b1;
         o_HSYNC       <= ~SYNC_POL;
         o_VSYNC       <= ~SYNC_POL;
      end else begin
         h             <= h_nxt;
         v             <= v_nxt;
         o_ACTIVE      <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
         o_FRAME_START <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
         o_HSYNC       <= (h_nxt >= HS_BEG && h_nxt < HS_END) ? SYNC_POL : ~SYNC_POL;
         o_VSYNC       <= (v_nxt >= VS_BEG && v_nxt < VS_END) ? SYNC_POL : ~SYNC_POL;
      end
   end

   assign o_X = h;
   assign o_Y = v;

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_CFG_VALID) state_nxt = PENDING;
         PENDING: if (fb)          state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_CFG_READY = (state == IDLE);
   end

`ifdef VGA_SCHED_AUTOCYCLE_EN
   localparam int             FC_W    = $clog2(AUTO_FRAMES + 1);
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(AUTO_FRAMES - 1);
   logic [FC_W-1:0] fc;
   logic            auto_step;

   // Only idle frame boundaries without a new offer count towards an auto step.
   assign auto_step = fb && (state == IDLE) && !i_CFG_VALID && (fc == FC_LAST);

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) fc <= '0;
      else if (fb) begin
         if (state == PENDING)  fc <= '0;
         else if (!i_CFG_VALID) fc <= (fc == FC_LAST) ? '0 : fc + 1'b1;
      end
   end
`else
   logic auto_step;
   assign auto_step = 1'b0;
`endif

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         shadow <= '0;
         o_MODE <= '0;
      end else begin
         if (state == IDLE && i_CFG_VALID) shadow <= i_CFG_DATA;
         if (state == PENDING && fb)       o_MODE <= shadow;
         else if (auto_step)               o_MODE <= o_MODE + 8'd1;
      end
   end

endmodule
